// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, default widths and helpers for the data-memory responder
package dmem_pkg;

    // Default data and word-address widths; the data width matches the register file
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 8;

    // Width of the wait-state counter (supports 0..15 wait states)
    localparam int DMEM_CNT_W  = 4;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    // Counter preload for a given number of wait states; zero wait states never use it
    function automatic logic [DMEM_CNT_W-1:0] dmem_wait_load(input int wait_cycles);
        if (wait_cycles > 0) begin
            return DMEM_CNT_W'(wait_cycles - 1);
        end
        return '0;
    endfunction

    // Index width needed to address DEPTH words (at least one bit)
    function automatic int dmem_idx_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end
        return 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x DATA_W storage, synchronous write, combinational read
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // Storage is deliberately not reset so contents survive a responder reset
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Commit a write on the clock edge while the write enable is held
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store memory responder with programmable wait states (option: DMEM_RANGE_CHECK_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
`ifdef DMEM_RANGE_CHECK_EN
    output logic              err,
`endif
    output logic [DATA_W-1:0] rdata
);

    localparam int                    IDX_W    = dmem_idx_w(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = dmem_wait_load(WAIT_CYCLES);

    dmem_state_t            r_state;
    dmem_state_t            w_next_state;
    logic [DMEM_CNT_W-1:0]  r_cnt;
    logic [DMEM_CNT_W-1:0]  w_cnt_next;
    logic                   w_capture;

    // Request fields frozen at capture; the initiator may change its pins afterwards
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;

    logic [IDX_W-1:0]       w_idx;
    logic                   w_oor;
    logic                   w_mem_we;
    logic [DATA_W-1:0]      w_rd_word;

    // Addresses beyond the implemented depth fold back modulo DEPTH
    assign w_idx = IDX_W'(32'(r_addr) % 32'(DEPTH));

`ifdef DMEM_RANGE_CHECK_EN
    assign w_oor = (32'(r_addr) >= 32'(DEPTH));
`else
    assign w_oor = 1'b0;
`endif

    // The write lands on the edge that leaves RESP, so an abort in WAIT never writes
    assign w_mem_we = (r_state == RESP) && r_we && !w_oor;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clock (clock),
        .i_we    (w_mem_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rd_word)
    );

    // State and wait-counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request fields once, when an idle responder sees req
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Next-state, counter and response outputs
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        busy         = 1'b0;
        ack          = 1'b0;
        rdata        = '0;
`ifdef DMEM_RANGE_CHECK_EN
        err          = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        w_next_state = WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end else begin
                        w_next_state = RESP;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                busy         = 1'b1;
                ack          = 1'b1;
                w_next_state = IDLE;
                if (!r_we && !w_oor) begin
                    rdata = w_rd_word;
                end
`ifdef DMEM_RANGE_CHECK_EN
                err = w_oor;
`endif
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder (three configurations)
module tb_dmem_responder;

    logic        clk;
    logic        rst_v   [3];
    logic        req_v   [3];
    logic        we_v    [3];
    logic [7:0]  addr_v  [3];
    logic [15:0] wdata_v [3];
    logic        busy_v  [3];
    logic        ack_v   [3];
    logic [15:0] rdata_v [3];
    logic        err_v   [3];

    int n_vec = 0;
    int n_err = 0;

    // Reference memory image per instance, plus which words have been written
    logic [15:0] mm [3][256];
    bit          mv [3][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: one wait state, full depth
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) u_dut0 (
        .clock(clk), .reset_n(rst_v[0]), .req(req_v[0]), .we(we_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .busy(busy_v[0]), .ack(ack_v[0]),
`ifdef DMEM_RANGE_CHECK_EN
        .err(err_v[0]),
`endif
        .rdata(rdata_v[0]));

    // Instance 1: zero wait states, full depth
    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
        .clock(clk), .reset_n(rst_v[1]), .req(req_v[1]), .we(we_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .busy(busy_v[1]), .ack(ack_v[1]),
`ifdef DMEM_RANGE_CHECK_EN
        .err(err_v[1]),
`endif
        .rdata(rdata_v[1]));

    // Instance 2: three wait states, 16 words
    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut2 (
        .clock(clk), .reset_n(rst_v[2]), .req(req_v[2]), .we(we_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]), .busy(busy_v[2]), .ack(ack_v[2]),
`ifdef DMEM_RANGE_CHECK_EN
        .err(err_v[2]),
`endif
        .rdata(rdata_v[2]));

`ifndef DMEM_RANGE_CHECK_EN
    initial begin
        for (int i = 0; i < 3; i++) err_v[i] = 1'b0;
    end
`endif

    function automatic int wc_of(input int d);
        case (d)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int dp_of(input int d);
        return (d == 2) ? 16 : 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d, checked against the reference image
    task automatic txn(input int d, input bit w, input logic [7:0] a, input logic [15:0] dat,
                       input bit pert, input bit pw, input logic [7:0] pa, input logic [15:0] pd,
                       input bit drop, input bit keep);
        int          ea;
        int          lat;
        int          waits;
        bit          oor;
        bit          rd_known;
        bit          got_cap;
        bit          got_ack;
        logic [15:0] exp_rd;
        ea  = int'(a) % dp_of(d);
        oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        oor = (int'(a) >= dp_of(d));
`endif
        rd_known = 1'b1;
        exp_rd   = 16'h0;
        if (!w && !oor) begin
            rd_known = mv[d][ea];
            exp_rd   = mm[d][ea];
        end
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = dat;
        got_cap = 1'b0;
        waits   = 0;
        while (!got_cap && waits < 4) begin
            @(posedge clk); #1;
            waits++;
            if (busy_v[d] === 1'b1) got_cap = 1'b1;
        end
        check("capture_wait", waits, 1);
        if (!got_cap) begin
            req_v[d] = 1'b0;
            return;
        end
        if (pert) begin
            we_v[d] = pw; addr_v[d] = pa; wdata_v[d] = pd;
        end
        if (drop) req_v[d] = 1'b0;
        lat     = 1;
        got_ack = 1'b0;
        while (!got_ack && lat <= 20) begin
            @(negedge clk);
            if (ack_v[d] === 1'b1) begin
                got_ack = 1'b1;
            end else begin
                check("busy_wait", busy_v[d], 1);
                check("rdata_wait", rdata_v[d], 0);
                lat++;
            end
        end
        check("latency", lat, wc_of(d) + 1);
        if (got_ack) begin
            check("busy_ack", busy_v[d], 1);
            if (rd_known) check("rdata", rdata_v[d], exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
            check("err", err_v[d], oor);
`endif
            if (w && !oor) begin
                mm[d][ea] = dat;
                mv[d][ea] = 1'b1;
            end
        end
        if (!keep) req_v[d] = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", ack_v[d], 0);
        check("idle_busy", busy_v[d], 0);
        check("idle_rdata", rdata_v[d], 0);
    endtask

    task automatic simple(input int d, input bit w, input logic [7:0] a, input logic [15:0] dat);
        txn(d, w, a, dat, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; req_v[i] = 1'b0; we_v[i] = 1'b0;
            addr_v[i] = 8'h0; wdata_v[i] = 16'h0;
        end

        // Reset held for three cycles, then released with req low
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check("rst_ack", ack_v[i], 0);
                check("rst_busy", busy_v[i], 0);
                check("rst_rdata", rdata_v[i], 0);
`ifdef DMEM_RANGE_CHECK_EN
                check("rst_err", err_v[i], 0);
`endif
            end
        end
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check("idle_ack", ack_v[i], 0);
                check("idle_busy0", busy_v[i], 0);
            end
        end
        @(posedge clk); #1;

        // Write then read, one wait state
        simple(0, 1'b1, 8'h05, 16'h000F);
        simple(0, 1'b0, 8'h05, 16'h0000);

        // Zero wait states, back-to-back with req held high between them
        txn(1, 1'b1, 8'h00, 16'h0007, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b1);
        simple(1, 1'b0, 8'h00, 16'h0000);

        // Pin changes after capture are ignored
        simple(0, 1'b1, 8'h04, 16'h5A5A);
        txn(0, 1'b1, 8'h03, 16'h1234, 1'b1, 1'b1, 8'h04, 16'hFFFF, 1'b1, 1'b0);
        simple(0, 1'b0, 8'h03, 16'h0000);
        simple(0, 1'b0, 8'h04, 16'h0000);

        // Reset during WAIT aborts the pending write
        simple(2, 1'b1, 8'h09, 16'h1111);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 8'h09; wdata_v[2] = 16'hBEEF;
        @(posedge clk); #1;
        check("midop_cap", busy_v[2], 1);
        req_v[2] = 1'b0;
        @(negedge clk);
        rst_v[2] = 1'b0;
        #1;
        check("midop_busy", busy_v[2], 0);
        repeat (4) begin
            @(negedge clk);
            check("midop_noack", ack_v[2], 0);
        end
        rst_v[2] = 1'b1;
        @(posedge clk); #1;
        simple(2, 1'b0, 8'h09, 16'h0000);
        check("midop_model", mm[2][9], 16'h1111);

        // Out-of-range write on the 16-word instance
        simple(2, 1'b1, 8'h04, 16'h4444);
        simple(2, 1'b1, 8'h14, 16'hAAAA);
        simple(2, 1'b0, 8'h04, 16'h0000);

        // Randomized traffic on each instance
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                txn(d, 1'($urandom), 8'($urandom_range(0, 31)), 16'($urandom),
                    1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
                    1'($urandom), (i != 39) && 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the CPU's load/store interface, which LW and SW will use.
- The CPU datapath acts as initiator: it asserts a request, holds address, write data and write enable stable, and waits for an acknowledge.
- The block serves each request after a programmable number of wait states, then returns one 16-bit read word or commits one write.
- It sits beside the register file and shares the single CPU clock.

Parameters:
- DATA_W, 16, data word width; matches the register file width.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 1, wait states inserted before the response (0..15).

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  initiator request; held high until ack is seen.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- busy  out  1  high from request capture through the ack cycle.
- ack  out  1  one-cycle response pulse.
- rdata  out  DATA_W  read data; valid only while ack=1 on a read.

Behaviour:
- Reset:
  - Asynchronous on reset_n low; one clock, reset is asynchronous and active-low.
  - Values during reset: state=IDLE, busy=0, ack=0, rdata=0, wait counter=0.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On posedge with req=1, capture we, addr and wdata into internal registers and set busy=1.
  - Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- RESP:
  - ack=1 for exactly one cycle.
  - Read: rdata = mem[captured addr].
  - Write: mem[captured addr] <= captured wdata on the posedge that leaves RESP; rdata=0.
  - Next state is IDLE; busy drops with ack.
- Latency: ack is asserted WAIT_CYCLES+1 cycles after the posedge that captured req.
- Handshake:
  - Inputs are captured once, so changes to addr, wdata or we after capture are ignored.
  - req is not re-sampled until the cycle after ack, so back-to-back requests get no bubble beyond IDLE (one IDLE cycle minimum).
  - If req drops before ack, the transaction still completes.
- Read-after-write to the same address returns the new data, because the write commits before the next capture.
- Out-of-range address (addr >= DEPTH):
  - Without the optional feature, the access uses addr modulo DEPTH.
  - With it, see Optional Feature.
- Reset mid-operation: the transaction is aborted and no memory write occurs unless the RESP posedge has already completed. ack is never issued for an aborted request.
- When rdata is not being driven with valid read data it is 0.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - A request with addr >= DEPTH completes with normal latency and ack=1, err=1, rdata=0.
  - No memory write occurs for such a request.
  - err is high only in the ack cycle.
- Undefined: no err port, and addresses wrap modulo DEPTH.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - Default widths DATA_W=16 and ADDR_W=8.
  - Wait-counter width of 4 bits.
- One sub-module, dmem_array:
  - DEPTH x DATA_W storage.
  - Synchronous write (clock, write enable, address, data) and combinational read.
- The responder FSM, capture registers and wait counter stay in the top module.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, then release with req=0 -> ack=0, busy=0, rdata=0 throughout.
- Write then read (WAIT_CYCLES=1):
  - Write addr=8'h05, wdata=16'h000F -> ack exactly 2 cycles after capture.
  - Then read addr=8'h05 -> ack in its 2nd cycle with rdata=16'h000F.
- Zero wait (WAIT_CYCLES=0): read of addr=8'h00 after writing 16'h0007 -> ack 1 cycle after capture with rdata=16'h0007. Back-to-back requests show a 1-cycle IDLE gap.
- Input stability:
  - Write addr=3, wdata=16'h1234, then change addr to 4 and wdata to 16'hFFFF during WAIT.
  - Reading addr=3 -> 16'h1234; reading addr=4 -> unchanged prior value.
- Reset mid-op (WAIT_CYCLES=3): capture a write of 16'hBEEF to addr=9, pull reset_n low in WAIT -> no ack; a later read of addr=9 returns the old value.
- Range check (DEPTH=16, DMEM_RANGE_CHECK_EN defined):
  - Write addr=8'h14 -> ack with err=1, and addr 8'h04 is unchanged.
  - With the macro undefined, the same write lands in addr 8'h04.
